seq_pair_loader: RTL

Upstream feeder for `BandedSWAccelerator`. Accepts a byte stream of ASCII nucleotides over a valid/ready handshake and packs them 2 bits per base into a reference word `R` and a query word `Q`. It then launches the accelerator with a one-cycle `start` pulse and withholds the next pair until the accelerator reports completion on `ready`. A shadow buffer lets the next pair fill while the current alignment is running.

---
 rtl/seq_pair_loader.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/seq_pair_loader.sv
// seq_pair_loader
//
// Packs an ASCII nucleotide byte stream into a reference word R and a query word Q,
// at 2 bits per base and MSB-first. It then launches the downstream aligner with a
// one-cycle start pulse.
//
// A shadow buffer collects the next pair while the aligner is busy. R/Q are
// only updated when the aligner is idle, so they stay stable for a whole alignment.
//
// Build option:
//   SEQ_PAIR_LOADER_LOWERCASE_EN - when defined, the lowercase a/c/g/t are
//                                  legal bases. Otherwise they are illegal.
//
// Ports:
//   clk         - clock, rising edge
//   reset       - asynchronous active-high reset
//   in_data     - ASCII base character
//   in_valid    - in_data valid
//   in_ready    - loader can accept a byte (transfer on in_valid && in_ready)
//   R, Q        - packed reference / query words (2*N_BASES bits)
//   start       - one-cycle launch pulse to the aligner
//   accel_ready - aligner ready; a rising edge marks completion
//   bad_char    - sticky illegal-character flag
//   pair_count  - number of pairs launched (wraps)
module seq_pair_loader #(
  parameter int unsigned N_BASES = 12
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [2*N_BASES-1:0]   R,
  output logic [2*N_BASES-1:0]   Q,
  output logic                   start,
  input  logic                   accel_ready,
  output logic                   bad_char,
  output logic [15:0]            pair_count
);

  localparam int unsigned W    = 2 * N_BASES;
  localparam int unsigned CntW = $clog2(W);

  localparam logic [1:0] StFill   = 2'd0;
  localparam logic [1:0] StHold   = 2'd1;
  localparam logic [1:0] StLoad   = 2'd2;
  localparam logic [1:0] StLaunch = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] base_cnt_q, base_cnt_d;
  logic [W-1:0]    r_sh_q, r_sh_d;
  logic [W-1:0]    q_sh_q, q_sh_d;
  logic            full_q, full_d;
  logic            busy_q, busy_d;
  logic            acc_prev_q;
  logic [W-1:0]    r_q, q_q;
  logic            bad_q, bad_d;
  logic [15:0]     cnt_q;

  logic [1:0]      code;
  logic            illegal;
  logic            accept;
  logic            acc_rise;

  // Base encoding. An illegal character still takes a slot and is encoded as 00.
  always_comb begin
    code    = 2'b00;
    illegal = 1'b0;
    case (in_data)
      8'h41: code = 2'b00;  // A
      8'h43: code = 2'b01;  // C
      8'h47: code = 2'b10;  // G
      8'h54: code = 2'b11;  // T
`ifdef SEQ_PAIR_LOADER_LOWERCASE_EN
      8'h61: code = 2'b00;  // a
      8'h63: code = 2'b01;  // c
      8'h67: code = 2'b10;  // g
      8'h74: code = 2'b11;  // t
`endif
      default: illegal = 1'b1;
    endcase
  end

  assign accept   = in_valid && !full_q;
  assign acc_rise = accel_ready && !acc_prev_q;

  always_comb begin
    state_d    = state_q;
    base_cnt_d = base_cnt_q;
    r_sh_d     = r_sh_q;
    q_sh_d     = q_sh_q;
    full_d     = full_q;
    bad_d      = bad_q;

    // Shadow fill. A shift register gives MSB-first packing once all N bases are in.
    if (accept) begin
      if (base_cnt_q < CntW'(N_BASES)) begin
        r_sh_d = {r_sh_q[W-3:0], code};
      end else begin
        q_sh_d = {q_sh_q[W-3:0], code};
      end
      if (base_cnt_q == CntW'(W - 1)) begin
        base_cnt_d = '0;
        full_d     = 1'b1;
      end else begin
        base_cnt_d = base_cnt_q + CntW'(1);
      end
      if (illegal) begin
        bad_d = 1'b1;
      end
    end

    case (state_q)
      StFill:   if (full_q) state_d = StHold;
      StHold:   if (!busy_q) state_d = StLoad;
      StLoad: begin
        state_d = StLaunch;
        full_d  = 1'b0;
      end
      StLaunch: state_d = StFill;
      default:  state_d = StFill;
    endcase

    // A launch in the same cycle as a completion edge leaves busy set.
    if (state_q == StLaunch) begin
      busy_d = 1'b1;
    end else if (acc_rise) begin
      busy_d = 1'b0;
    end else begin
      busy_d = busy_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StFill;
      base_cnt_q <= '0;
      r_sh_q     <= '0;
      q_sh_q     <= '0;
      full_q     <= 1'b0;
      busy_q     <= 1'b0;
      acc_prev_q <= 1'b0;
      r_q        <= '0;
      q_q        <= '0;
      bad_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      base_cnt_q <= base_cnt_d;
      r_sh_q     <= r_sh_d;
      q_sh_q     <= q_sh_d;
      full_q     <= full_d;
      busy_q     <= busy_d;
      acc_prev_q <= accel_ready;
      bad_q      <= bad_d;
      // R/Q are captured on the edge into LOAD and hold until the next pair.
      if (state_q == StHold && !busy_q) begin
        r_q <= r_sh_q;
        q_q <= q_sh_q;
      end
      if (state_q == StLaunch) begin
        cnt_q <= cnt_q + 16'd1;
      end
    end
  end

  assign in_ready   = !full_q;
  assign start      = (state_q == StLaunch);
  assign R          = r_q;
  assign Q          = q_q;
  assign bad_char   = bad_q;
  assign pair_count = cnt_q;

endmodule
